// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one variable-latency req/ack memory port between the Fetch stage
// (instruction reads) and the Memory stage (data reads/writes). The Memory
// stage wins ties unless it was served last, accesses are bounded by a
// timeout, and an in-flight fetch can be discarded by a redirect.
module mem_port_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   // fetch stage
   input  logic        F_req,
   input  logic [63:0] F_addr,
   input  logic        F_flush,
   // memory stage
   input  logic        M_rd,
   input  logic        M_wr,
   input  logic [63:0] M_addr,
   input  logic [63:0] M_wdata,
   // completion and stall
   output logic        F_done,
   output logic        M_done,
   output logic [79:0] F_rdata,
   output logic [63:0] M_rdata,
   output logic        F_err,
   output logic        M_err,
   output logic        F_stall_req,
   output logic        M_stall_req,
   // memory port
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [79:0] mem_rdata,
   input  logic        mem_err
);

   // Counter only has to reach TIMEOUT-1 before the access is forced closed.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TCOUNT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_M = 2'd1,
      SERVE_F = 2'd2
   } state_t;

   state_t         state_q,      state_d;
   logic           last_was_m_q, last_was_m_d;
   logic           flush_pend_q, flush_pend_d;
   logic [TW-1:0]  tcount_q,     tcount_d;
   logic           mem_we_q,     mem_we_d;
   logic [63:0]    mem_addr_q,   mem_addr_d;
   logic [63:0]    mem_wdata_q,  mem_wdata_d;
   logic           f_done_q,     f_done_d;
   logic           f_err_q,      f_err_d;
   logic [79:0]    f_rdata_q,    f_rdata_d;
   logic           m_done_q,     m_done_d;
   logic           m_err_q,      m_err_d;
   logic [63:0]    m_rdata_q,    m_rdata_d;

   logic m_any;
   logic in_service;
   logic timed_out;
   logic serve_end;
   logic done_pulse;

   assign m_any      = M_rd | M_wr;
   assign in_service = (state_q != IDLE);
   assign timed_out  = (tcount_q == TCOUNT_LAST);
   assign serve_end  = in_service & (mem_ack | timed_out);
   // While a done pulse is out the requester has not yet seen it, so its
   // request line still shows the finished access.
   assign done_pulse = f_done_q | m_done_q;

   // Next-state, arbitration, completion capture and flush tracking.
   always_comb begin
      state_d      = state_q;
      last_was_m_d = last_was_m_q;
      flush_pend_d = flush_pend_q;
      tcount_d     = tcount_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      f_done_d     = 1'b0;
      f_err_d      = f_err_q;
      f_rdata_d    = f_rdata_q;
      m_done_d     = 1'b0;
      m_err_d      = m_err_q;
      m_rdata_d    = m_rdata_q;

      case (state_q)
         IDLE: begin
            tcount_d = '0;
            if (!done_pulse) begin
               if (m_any && (!F_req || !last_was_m_q)) begin
                  state_d     = SERVE_M;
                  mem_addr_d  = M_addr;
                  mem_we_d    = M_wr;          // rd+wr together counts as a write
                  mem_wdata_d = M_wdata;
               end else if (F_req) begin
                  state_d    = SERVE_F;
                  mem_addr_d = F_addr;
                  mem_we_d   = 1'b0;
               end
            end
         end

         SERVE_M: begin
            tcount_d = tcount_q + 1'b1;
            if (serve_end) begin
               state_d      = IDLE;
               tcount_d     = '0;
               last_was_m_d = 1'b1;
               m_done_d     = 1'b1;
               m_err_d      = mem_ack ? mem_err : 1'b1;
               m_rdata_d    = (mem_ack && !mem_we_q) ? mem_rdata[63:0] : 64'd0;
            end
         end

         SERVE_F: begin
            tcount_d = tcount_q + 1'b1;
            if (F_flush) begin
               flush_pend_d = 1'b1;
            end
            if (serve_end) begin
               state_d      = IDLE;
               tcount_d     = '0;
               last_was_m_d = 1'b0;
               if (flush_pend_q || F_flush) begin
                  // Redirected fetch: drop the result, refetch from the new address.
                  flush_pend_d = 1'b0;
               end else begin
                  f_done_d  = 1'b1;
                  f_err_d   = mem_ack ? mem_err : 1'b1;
                  f_rdata_d = mem_ack ? mem_rdata : 80'd0;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_was_m_q <= 1'b0;
         flush_pend_q <= 1'b0;
         tcount_q     <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 64'd0;
         mem_wdata_q  <= 64'd0;
         f_done_q     <= 1'b0;
         f_err_q      <= 1'b0;
         f_rdata_q    <= 80'd0;
         m_done_q     <= 1'b0;
         m_err_q      <= 1'b0;
         m_rdata_q    <= 64'd0;
      end else begin
         state_q      <= state_d;
         last_was_m_q <= last_was_m_d;
         flush_pend_q <= flush_pend_d;
         tcount_q     <= tcount_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         f_done_q     <= f_done_d;
         f_err_q      <= f_err_d;
         f_rdata_q    <= f_rdata_d;
         m_done_q     <= m_done_d;
         m_err_q      <= m_err_d;
         m_rdata_q    <= m_rdata_d;
      end
   end

   assign mem_req     = in_service;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign F_done      = f_done_q;
   assign F_err       = f_err_q;
   assign F_rdata     = f_rdata_q;
   assign M_done      = m_done_q;
   assign M_err       = m_err_q;
   assign M_rdata     = m_rdata_q;
   assign F_stall_req = F_req & ~f_done_q;
   assign M_stall_req = m_any & ~m_done_q;

endmodule
